// File: rtl/mux_2x1_if.sv
// Bundle of the selector's data-path signals, for environments that prefer
// to pass the mux connection around as one handle. The master side owns the
// data inputs and select; the slave side owns the combinational and
// registered results. mux_2x1 keeps plain ports so parents that instantiate
// it per bit can wire individual nets directly.
interface mux_2x1_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic             sel;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] out_q;
    logic             sel_q;

    // Master drives the choice and the candidates; it observes the results.
    modport master (
        output in0,
        output in1,
        output sel,
        input  out,
        input  out_q,
        input  sel_q
    );

    // Slave is the selector itself.
    modport slave (
        input  in0,
        input  in1,
        input  sel,
        output out,
        output out_q,
        output sel_q
    );
endinterface

// File: rtl/mux_2x1.sv
// Bit-parallel 2-to-1 selector: leaf primitive of the display-map muxes.
// 'out' is the zero-latency selection; 'out_q'/'sel_q' are a registered copy
// one cycle behind it for consumers that need a flop boundary.
// There is no handshake: every output is meaningful every cycle.
module mux_2x1 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             sel,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic             sel_q
);
    logic [WIDTH-1:0] sel_vec;

    assign sel_vec = {WIDTH{sel}};

    // Consensus form: the (in0 & in1) term holds the output steady whenever
    // both candidates agree, so a toggling or unknown select cannot glitch or
    // pollute such bits. The redundant term must survive; it is the point.
    assign out = (in0 & ~sel_vec) | (in1 & sel_vec) | (in0 & in1);

    // Registered copy of the selection and its select; reset clears only
    // these, the combinational path stays live during reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
            sel_q <= 1'b0;
        end else begin
            out_q <= out;
            sel_q <= sel;
        end
    end
endmodule

// File: tb/tb_mux_2x1.sv
// Bench for mux_2x1: a WIDTH=1 instance exercised exhaustively on the
// combinational path, and a WIDTH=7 instance driven cycle by cycle. Each
// driven cycle checks 'out' at once and queues the expected {out_q, sel_q}
// for the following edge; an independent monitor pops and compares.
module tb_mux_2x1;
    logic clk;
    logic rst;

    // WIDTH=1 instance
    logic w1_in0, w1_in1, w1_sel;
    logic w1_out, w1_out_q, w1_sel_q;

    // WIDTH=7 instance, connected through the interface bundle
    mux_2x1_if #(.WIDTH(7)) bus ();

    logic [7:0] exp_q[$];
    int         n_cmp;
    int         n_bad;

    mux_2x1 #(.WIDTH(1)) u_w1 (
        .clk   (clk),
        .rst   (rst),
        .in0   (w1_in0),
        .in1   (w1_in1),
        .sel   (w1_sel),
        .out   (w1_out),
        .out_q (w1_out_q),
        .sel_q (w1_sel_q)
    );

    mux_2x1 #(.WIDTH(7)) u_w7 (
        .clk   (clk),
        .rst   (rst),
        .in0   (bus.in0),
        .in1   (bus.in1),
        .sel   (bus.sel),
        .out   (bus.out),
        .out_q (bus.out_q),
        .sel_q (bus.sel_q)
    );

    // Clock: period 10, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference selection: plain choice between the two candidates.
    function automatic logic [6:0] model(input logic [6:0] a, input logic [6:0] b,
                                         input logic s);
        return s ? b : a;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // One driven cycle on the 7-bit instance: apply inputs after the edge,
    // check the combinational result, queue the registered expectation.
    task automatic cycle(input logic r, input logic [6:0] a, input logic [6:0] b,
                         input logic s);
        logic [6:0] sel_val;
        @(posedge clk);
        #2;
        rst     = r;
        bus.in0 = a;
        bus.in1 = b;
        bus.sel = s;
        #1;
        sel_val = model(a, b, s);
        check("out7", {1'b0, bus.out}, {1'b0, sel_val});
        exp_q.push_back(r ? 8'h00 : {sel_val, s});
    endtask

    // Agreeing candidates with an unknown and then toggling select:
    // the output must stay on the shared pattern at every step.
    task automatic toggle_cycle(input logic [6:0] pat);
        logic s;
        @(posedge clk);
        #2;
        rst     = 1'b0;
        bus.in0 = pat;
        bus.in1 = pat;
        bus.sel = 1'bx;
        #1;
        check("out_selx", {1'b0, bus.out}, {1'b0, pat});
        s = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.sel = s;
            #1;
            check("out_toggle", {1'b0, bus.out}, {1'b0, pat});
            s = ~s;
        end
        exp_q.push_back({pat, bus.sel});
    endtask

    // Monitor: one registered result per edge, compared in order.
    always @(posedge clk) begin
        logic [7:0] e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("out_q", {1'b0, bus.out_q}, {1'b0, e[7:1]});
            check("sel_q", {7'b0, bus.sel_q}, {7'b0, e[0]});
        end
    end

    initial begin
        logic [2:0] combo;
        logic [6:0] ra, rb;
        logic       rs, rr;
        n_cmp   = 0;
        n_bad   = 0;
        rst     = 1'b1;
        w1_in0  = 1'b0;
        w1_in1  = 1'b0;
        w1_sel  = 1'b0;
        bus.in0 = '0;
        bus.in1 = '0;
        bus.sel = 1'b0;

        // Reset state of the registered outputs
        cycle(1'b1, 7'h00, 7'h00, 1'b0);
        cycle(1'b1, 7'h00, 7'h00, 1'b0);

        // WIDTH=1 exhaustive, combinational only
        for (int i = 0; i < 8; i++) begin
            combo  = i[2:0];
            w1_in0 = combo[0];
            w1_in1 = combo[1];
            w1_sel = combo[2];
            #1;
            check("out1", {7'b0, w1_out}, {7'b0, (combo[2] ? combo[1] : combo[0])});
        end

        // Registered path: select flips 0 -> 1 before the third edge
        cycle(1'b0, 7'b1000001, 7'b1100011, 1'b0);
        cycle(1'b0, 7'b1000001, 7'b1100011, 1'b0);
        cycle(1'b0, 7'b1000001, 7'b1100011, 1'b1);
        cycle(1'b0, 7'b1000001, 7'b1100011, 1'b1);

        // Reset mid-operation: out follows in1, registers held at zero
        cycle(1'b1, 7'h00, 7'h7F, 1'b1);
        cycle(1'b1, 7'h00, 7'h7F, 1'b1);
        cycle(1'b0, 7'h00, 7'h7F, 1'b1);
        cycle(1'b0, 7'h00, 7'h7F, 1'b1);

        // Consensus with unknown and toggling select
        toggle_cycle(7'b1010101);
        toggle_cycle(7'b0101010);

        // Randomized traffic with occasional reset
        for (int i = 0; i < 1000; i++) begin
            ra = 7'($urandom_range(0, 127));
            rb = 7'($urandom_range(0, 127));
            rs = 1'($urandom_range(0, 1));
            rr = ($urandom_range(0, 31) == 0);
            cycle(rr, ra, rb, rs);
        end

        // Let the monitor drain the last expectation
        repeat (2) @(posedge clk);
        #2;
        check("queue_drained", 8'(exp_q.size()), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mux_2x1.md
Name: mux_2x1

Overview:
- Bit-parallel 2-to-1 selector, the leaf primitive of the display-map multiplexers: an N-bit map mux is N width-1 instances sharing one select, or one instance with WIDTH=N.
- Provides a zero-latency combinational output, plus a registered copy for timing-closed consumers.
- Single clock domain; synchronous active-high reset.

Parameters:
- WIDTH, 1, bit width of in0, in1, out, out_q.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  synchronous reset, active-high; affects registered outputs only
- in0  input  WIDTH  data selected when sel=0
- in1  input  WIDTH  data selected when sel=1
- sel  input  1  select; 0 -> in0, 1 -> in1
- out  output  WIDTH  combinational selected data
- out_q  output  WIDTH  registered selected data
- sel_q  output  1  registered copy of sel, aligned with out_q

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- out[i] = (in0[i] & ~sel) | (in1[i] & sel) | (in0[i] & in1[i]) for every bit i. This is the consensus form.
- When in0[i] == in1[i], out[i] equals that value regardless of sel. This also holds while sel toggles and when sel is X in simulation.
- out is purely combinational, with zero latency from any input change. It is not gated by rst and is valid during reset.
- On each rising clk edge with rst=1: out_q <= 0 and sel_q <= 0.
- On each rising clk edge with rst=0: out_q <= the combinational out value, and sel_q <= sel.
- Latency of out_q is exactly 1 cycle. There is no enable and no stall; the register updates every cycle.
- No handshake and no state machine. No arithmetic; no width conversion.
- Reset mid-operation: out_q and sel_q are 0 on the cycle after rst is sampled high. They remain 0 while rst is held, and follow inputs again 1 cycle after rst deasserts. out is unaffected throughout.
- All outputs are driven at all times; no tri-state.

Decomposition:
- No shared package needed; the block defines no typedefs or constants beyond WIDTH.
- No sub-module: the bit equation is written directly, with a generate loop over WIDTH or a vector expression.
- The parent map mux instantiates mux_2x1 per bit, or once with WIDTH=7.

Test Plan:
- WIDTH=1 exhaustive: all 8 combinations of in0, in1, sel -> out equals in1 when sel=1, in0 when sel=0; checked combinationally within the same timestep.
- WIDTH=7, in0=7'b1000001, in1=7'b1100011, sel=0 -> out=7'b1000001; then sel=1 -> out=7'b1100011 immediately, with no clock required.
- Registered path: same 7-bit values, rst=0, sel 0->1 before edge k -> out_q=7'b1000001 through edge k-1, and out_q=7'b1100011 plus sel_q=1 after edge k.
- Reset: rst=1 for 2 cycles with sel=1, in1=7'h7F -> out_q=0 and sel_q=0 during reset while out=7'h7F. rst=0 -> out_q=7'h7F one edge later.
- Consensus/X-safety: in0=in1=7'b1010101, sel driven X then toggled every 1 ns -> out stays 7'b1010101 with no X and no glitch.
- Independence: randomized in0, in1, sel for 1000 cycles -> out matches reference equation every timestep; out_q matches previous-cycle out every edge.
